// File: rtl/resize_coord_gen_pkg.sv
// Shared constants, state/mode enums and job/beat records for the resize
// coordinate generator.
package pkg_resize_coord_gen;

    localparam int FRAC_BITS = 18;
    localparam int INT_BITS  = 14;
    localparam int IDX_W     = 12;
    localparam int SCALE_W   = INT_BITS + FRAC_BITS;
    // One extra sign bit plus a full index of headroom, so acc can never wrap.
    localparam int ACC_W     = IDX_W + INT_BITS + FRAC_BITS + 1;

    localparam logic [SCALE_W-1:0] ONE_HALF = SCALE_W'(1) << (FRAC_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} STATES_t;
    typedef enum logic [1:0] {M_HALF, M_CORNER, M_NEAREST} MODE_t;

    typedef struct packed {
        logic [1:0]         mode;
        logic [SCALE_W-1:0] scale;
        logic [IDX_W-1:0]   src_len;
        logic [IDX_W-1:0]   dst_len;
    } struct_resize_coord_in;

    typedef struct packed {
        logic [IDX_W-1:0]     sx;
        logic [FRAC_BITS-1:0] fx;
        logic [IDX_W-1:0]     idx;
        logic                 last;
    } struct_resize_coord_out;

endpackage

// File: rtl/resize_coord_gen_if.sv
// Job request, coordinate stream and completion handshake between the resize
// controller (master) and the coordinate generator (slave).
interface resize_coord_if;
    import pkg_resize_coord_gen::*;

    logic                 start;
    logic                 ready;
    logic [1:0]           mode;
    logic [SCALE_W-1:0]   scale;
    logic [IDX_W-1:0]     src_len;
    logic [IDX_W-1:0]     dst_len;
    logic                 out_valid;
    logic                 out_ready;
    logic [IDX_W-1:0]     out_sx;
    logic [FRAC_BITS-1:0] out_fx;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_last;
    logic                 done;
    logic                 taken;

    modport master (
        output start, mode, scale, src_len, dst_len, out_ready, taken,
        input  ready, out_valid, out_sx, out_fx, out_idx, out_last, done
    );

    modport slave (
        input  start, mode, scale, src_len, dst_len, out_ready, taken,
        output ready, out_valid, out_sx, out_fx, out_idx, out_last, done
    );

endinterface

// File: rtl/resize_coord_gen_clamp.sv
// Splits a signed fixed-point source position into an integer index and a
// fractional weight, clamped into the source range [0, max(src_len,1)-1].
module resize_coord_clamp
    import pkg_resize_coord_gen::*;
(
    input  logic signed [ACC_W-1:0] acc,
    input  logic [IDX_W-1:0]        src_len,
    input  logic [1:0]              mode,
    output logic [IDX_W-1:0]        sx,
    output logic [FRAC_BITS-1:0]    fx
);

    logic [IDX_W-1:0]           len_m1;
    logic [ACC_W-FRAC_BITS-1:0] acc_int;
    logic [ACC_W-FRAC_BITS-1:0] lim;

    // Clamp order matters: negative wins over the upper bound.
    always_comb begin
        len_m1  = (src_len == '0) ? '0 : src_len - IDX_W'(1);
        acc_int = acc[ACC_W-1:FRAC_BITS];
        lim     = (ACC_W-FRAC_BITS)'(len_m1);
        if (acc[ACC_W-1]) begin
            sx = '0;
            fx = '0;
        end else if (acc_int >= lim) begin
            sx = len_m1;
            fx = '0;
        end else begin
            sx = acc_int[IDX_W-1:0];
            fx = acc[FRAC_BITS-1:0];
        end
        if (mode == M_NEAREST) begin
            fx = '0;
        end
    end

endmodule

// File: rtl/resize_coord_gen.sv
// Streams one (sx, fx) source coordinate per destination index for one resize
// axis, stepping an accumulator by scale each beat.
module resize_coord_gen (
    input  logic            clk,
    input  logic            resetn,
    resize_coord_if.slave   bus
);
    import pkg_resize_coord_gen::*;

    STATES_t                 state;
    struct_resize_coord_in   cfg;
    struct_resize_coord_out  beat;
    logic signed [ACC_W-1:0] acc;
    logic [IDX_W-1:0]        idx;
    logic                    issued_last;
    logic                    out_valid;
    logic                    ready_r;
    logic                    done_r;

    logic signed [ACC_W-1:0] scale_ext;
    logic signed [ACC_W-1:0] half_ext;
    logic signed [ACC_W-1:0] acc_init;
    logic [IDX_W-1:0]        last_idx;
    logic                    fire;
    logic                    load;
    logic [IDX_W-1:0]        clamp_sx;
    logic [FRAC_BITS-1:0]    clamp_fx;

    resize_coord_clamp u_clamp (
        .acc     (acc),
        .src_len (cfg.src_len),
        .mode    (cfg.mode),
        .sx      (clamp_sx),
        .fx      (clamp_fx)
    );

    // Half-pixel centres start at scale/2 - 0.5; mode 3 falls back to that too.
    always_comb begin
        scale_ext = {{(ACC_W-SCALE_W){1'b0}}, cfg.scale};
        half_ext  = {{(ACC_W-SCALE_W){1'b0}}, ONE_HALF};
        if (cfg.mode == M_CORNER || cfg.mode == M_NEAREST) begin
            acc_init = '0;
        end else begin
            acc_init = (scale_ext >>> 1) - half_ext;
        end
        last_idx = cfg.dst_len - IDX_W'(1);
        fire     = out_valid && bus.out_ready;
        load     = (state == S_RUN) && !issued_last && (!out_valid || bus.out_ready);
    end

    // Control FSM with a one-deep output register; issued_last stops refills
    // once the final beat is in the register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            cfg         <= '0;
            beat        <= '0;
            acc         <= '0;
            idx         <= '0;
            issued_last <= 1'b0;
            out_valid   <= 1'b0;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        cfg     <= '{mode: bus.mode, scale: bus.scale,
                                     src_len: bus.src_len, dst_len: bus.dst_len};
                        state   <= S_INIT;
                        ready_r <= 1'b0;
                    end
                end
                S_INIT: begin
                    acc         <= acc_init;
                    idx         <= '0;
                    issued_last <= 1'b0;
                    if (cfg.dst_len == '0) begin
                        state  <= S_DONE;
                        done_r <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (load) begin
                        beat.sx     <= clamp_sx;
                        beat.fx     <= clamp_fx;
                        beat.idx    <= idx;
                        beat.last   <= (idx == last_idx);
                        out_valid   <= 1'b1;
                        issued_last <= (idx == last_idx);
                        acc         <= acc + scale_ext;
                        idx         <= idx + IDX_W'(1);
                    end
                    if (fire && beat.last) begin
                        out_valid <= 1'b0;
                        state     <= S_DONE;
                        done_r    <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.taken) begin
                        state   <= S_IDLE;
                        done_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready     = ready_r;
    assign bus.done      = done_r;
    assign bus.out_valid = out_valid;
    assign bus.out_sx    = beat.sx;
    assign bus.out_fx    = beat.fx;
    assign bus.out_idx   = beat.idx;
    assign bus.out_last  = beat.last;

endmodule

// File: tb/tb_resize_coord_gen.sv
// Directed bench for resize_coord_gen: hand-computed coordinate tables,
// backpressure, mid-job reset and the empty-job/done handshake.
module tb_resize_coord_gen;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [11:0] exp_sx [0:7];
    logic [17:0] exp_fx [0:7];

    resize_coord_if bus ();

    resize_coord_gen dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called on a negedge with ready high; returns on the negedge after the accept edge.
    task automatic applyStimulus(input logic [1:0] m, input logic [31:0] s,
                                 input logic [11:0] src, input logic [11:0] dst);
        bus.mode    = m;
        bus.scale   = s;
        bus.src_len = src;
        bus.dst_len = dst;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // Consume n beats against exp_sx/exp_fx, stalling 3 clks at stall_beat (-1: none).
    task automatic collect(input string tag, input int n, input int stall_beat);
        int k = 0;
        int stall_left = 3;
        int budget = 0;
        bit have_hold = 1'b0;
        logic [11:0] h_sx = '0;
        logic [17:0] h_fx = '0;
        while (k < n && budget < 100) begin
            @(negedge clk);
            budget++;
            if (bus.out_valid) begin
                if (k == 0) checkOutput({tag, "_latency"}, budget, 2);
                if (k == stall_beat && stall_left > 0) begin
                    if (have_hold) begin
                        checkOutput({tag, "_hold_sx"}, bus.out_sx, h_sx);
                        checkOutput({tag, "_hold_fx"}, bus.out_fx, h_fx);
                    end
                    h_sx = bus.out_sx;
                    h_fx = bus.out_fx;
                    have_hold = 1'b1;
                    stall_left--;
                    bus.out_ready = 1'b0;
                end else begin
                    if (k == stall_beat && have_hold) begin
                        checkOutput({tag, "_hold_sx"}, bus.out_sx, h_sx);
                        checkOutput({tag, "_hold_fx"}, bus.out_fx, h_fx);
                    end
                    bus.out_ready = 1'b1;
                    checkOutput($sformatf("%s_sx%0d", tag, k), bus.out_sx, exp_sx[k]);
                    checkOutput($sformatf("%s_fx%0d", tag, k), bus.out_fx, exp_fx[k]);
                    checkOutput($sformatf("%s_idx%0d", tag, k), bus.out_idx, k);
                    checkOutput($sformatf("%s_last%0d", tag, k), bus.out_last, (k == n - 1));
                    k++;
                end
            end else begin
                bus.out_ready = 1'b1;
            end
        end
        checkOutput({tag, "_beats"}, k, n);
    endtask

    task automatic finish_job(input string tag);
        @(negedge clk);
        checkOutput({tag, "_valid_after"}, bus.out_valid, 0);
        checkOutput({tag, "_done"}, bus.done, 1);
        checkOutput({tag, "_ready_busy"}, bus.ready, 0);
        bus.taken = 1'b1;
        @(negedge clk);
        bus.taken = 1'b0;
        checkOutput({tag, "_done_clr"}, bus.done, 0);
        checkOutput({tag, "_ready_back"}, bus.ready, 1);
    endtask

    initial begin
        bus.start = 0; bus.mode = 0; bus.scale = 0; bus.src_len = 0; bus.dst_len = 0;
        bus.out_ready = 1; bus.taken = 0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", bus.ready, 1);
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_sx", bus.out_sx, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Half-pixel, downscale by 2.
        exp_sx = '{0, 2, 4, 6, 0, 0, 0, 0};
        exp_fx = '{18'h20000, 18'h20000, 18'h20000, 18'h20000, 0, 0, 0, 0};
        applyStimulus(2'd0, 32'h80000, 12'd8, 12'd4);
        checkOutput("t1_ready_low", bus.ready, 0);
        checkOutput("t1_valid_e0", bus.out_valid, 0);
        collect("t1", 4, -1);
        finish_job("t1");

        // Half-pixel, upscale by 2 with both clamps.
        exp_sx = '{0, 0, 0, 1, 1, 2, 2, 3};
        exp_fx = '{0, 18'h10000, 18'h30000, 18'h10000, 18'h30000, 18'h10000, 18'h30000, 0};
        applyStimulus(2'd0, 32'h20000, 12'd4, 12'd8);
        collect("t2", 8, -1);
        finish_job("t2");

        // Align-corners.
        exp_sx = '{0, 0, 1, 1, 2, 2, 3, 0};
        exp_fx = '{0, 18'h20000, 0, 18'h20000, 0, 18'h20000, 0, 0};
        applyStimulus(2'd1, 32'h20000, 12'd4, 12'd7);
        collect("t3", 7, -1);
        finish_job("t3");

        // Backpressure on beat 2.
        exp_sx = '{0, 2, 4, 6, 0, 0, 0, 0};
        exp_fx = '{18'h20000, 18'h20000, 18'h20000, 18'h20000, 0, 0, 0, 0};
        applyStimulus(2'd0, 32'h80000, 12'd8, 12'd4);
        collect("t4", 4, 2);
        finish_job("t4");

        // Nearest forces fx to zero.
        exp_sx = '{0, 0, 1, 0, 0, 0, 0, 0};
        exp_fx = '{0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(2'd2, 32'h20000, 12'd4, 12'd3);
        collect("t_near", 3, -1);
        finish_job("t_near");

        // Mode 3 behaves as half-pixel; src_len 0 clamps to index 0.
        exp_sx = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_fx = '{18'h20000, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(2'd3, 32'h80000, 12'd8, 12'd1);
        collect("t_m3", 1, -1);
        finish_job("t_m3");
        exp_fx = '{0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(2'd1, 32'h80000, 12'd0, 12'd2);
        collect("t_src0", 2, -1);
        finish_job("t_src0");

        // Reset while beat 1 is presented, then a fresh job from idx 0.
        begin
            bit seen = 1'b0;
            applyStimulus(2'd0, 32'h80000, 12'd8, 12'd4);
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (bus.out_valid && bus.out_idx == 12'd1) seen = 1'b1;
            end
            checkOutput("t5_beat1_seen", seen, 1);
            resetn = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
            checkOutput("t5_valid", bus.out_valid, 0);
            checkOutput("t5_ready", bus.ready, 1);
            checkOutput("t5_done", bus.done, 0);
            exp_sx = '{0, 0, 1, 1, 2, 2, 3, 0};
            exp_fx = '{0, 18'h20000, 0, 18'h20000, 0, 18'h20000, 0, 0};
            applyStimulus(2'd1, 32'h20000, 12'd4, 12'd7);
            collect("t5_new", 7, -1);
            finish_job("t5_new");
        end

        // Empty job, done held until taken, taken beats a simultaneous start.
        applyStimulus(2'd0, 32'h80000, 12'd8, 12'd0);
        checkOutput("t6_done_e0", bus.done, 0);
        @(negedge clk);
        checkOutput("t6_done_e1", bus.done, 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t6_hold_done%0d", i), bus.done, 1);
            checkOutput($sformatf("t6_no_valid%0d", i), bus.out_valid, 0);
            @(negedge clk);
        end
        bus.taken = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.taken = 1'b0;
        bus.start = 1'b0;
        checkOutput("t6_done_clr", bus.done, 0);
        checkOutput("t6_ready", bus.ready, 1);
        @(negedge clk);
        checkOutput("t6_start_ignored", bus.ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
